mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_dcnt.sv | 42 ++++
 rtl/mul_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-free multiplier controller:
// state encoding, default widths and the cycle-counter width.
package mul_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DW_DEF    = 16;
  localparam int CYC_W     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } mul_state_e;

endpackage

// File: rtl/mul_dcnt.sv
// Loadable down-counter holding the remaining multiplier count.
// Decrement stops at zero so the count can never wrap.
module mul_dcnt
  import mul_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             dec,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] dout,
  output logic             eqz
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement, decrement holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = din;
    end else if (dec && !eqz) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dout = cnt_q;
  assign eqz  = (cnt_q == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Controller for a repeated-addition multiplier: loads A, clears P,
// then strobes P <= P + A once per count of B. All outputs are Moore.
// Optional feature: define MUL_CYCLE_CNT_EN to add the cyc_cnt output,
// a saturating count of the add cycles of the last multiply.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [DW-1:0]    data_in,
  output logic             ldA,
  output logic             clrP,
  output logic             ldP,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] b_cnt
`ifdef MUL_CYCLE_CNT_EN
  ,
  output logic [CYC_W-1:0] cyc_cnt
`endif
);

  mul_state_e state_q;
  mul_state_e state_d;
  logic       cnt_ld;
  logic       cnt_dec;
  logic       cnt_eqz;

  mul_dcnt #(
    .CNT_W(CNT_W)
  ) u_dcnt (
    .clk  (clk),
    .clr  (clr),
    .ld   (cnt_ld),
    .dec  (cnt_dec),
    .din  (data_in[CNT_W-1:0]),
    .dout (b_cnt),
    .eqz  (cnt_eqz)
  );

  // State register; reset takes priority over any pending start.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore strobes decoded from the registered state and count.
  always_comb begin
    state_d = state_q;
    ldA     = 1'b0;
    clrP    = 1'b0;
    ldP     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        busy    = 1'b1;
        ldA     = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        busy    = 1'b1;
        clrP    = 1'b1;
        cnt_ld  = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (cnt_eqz) begin
          state_d = DONE;
        end else begin
          ldP     = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        // Level handshake: a held start keeps us here instead of retriggering.
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MUL_CYCLE_CNT_EN
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_d;

  // Add-cycle counter: cleared on a new operand load, counts strobed adds, saturates.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == LOAD_A) begin
      cyc_d = '0;
    end else if ((state_q == ADD) && !cnt_eqz && (cyc_q != {CYC_W{1'b1}})) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // Add-cycle counter register.
  always_ff @(posedge clk) begin
    if (clr) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. Models the product datapath the
// controller drives and compares against A*B computed arithmetically.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] data_in;
  logic        ldA;
  logic        clrP;
  logic        ldP;
  logic        busy;
  logic        done;
  logic [15:0] b_cnt;
`ifdef MUL_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] a_reg;
  logic [15:0] p_reg;

  mul_seq_ctrl #(
    .CNT_W(16),
    .DW   (16)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .data_in(data_in),
    .ldA    (ldA),
    .clrP   (clrP),
    .ldP    (ldP),
    .busy   (busy),
    .done   (done),
    .b_cnt  (b_cnt)
`ifdef MUL_CYCLE_CNT_EN
    ,
    .cyc_cnt(cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand and product registers steered by the controller strobes.
  always @(posedge clk) begin
    if (ldA === 1'b1) a_reg <= data_in;
    if (clrP === 1'b1) p_reg <= 16'd0;
    else if (ldP === 1'b1) p_reg <= p_reg + a_reg;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = {16'd0, a} * {16'd0, b};
    return full[15:0];
  endfunction

  // Drives one multiply from IDLE and returns what was observed.
  // lat counts edges after the start-sampling edge until done is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic hold,
                        input bit pulse, output int lat, output int nldp,
                        output int excl_bad, output int bcnt_bad,
                        output logic lda0, output logic clrp1);
    int e;
    int bound;
    int bi;
    int exp_b;
    nldp = 0;
    excl_bad = 0;
    bcnt_bad = 0;
    bi = int'(b);
    start = 1'b1;
    data_in = 16'($urandom);
    step;
    e = 0;
    lda0 = ldA;
    if (int'(ldA) + int'(clrP) + int'(ldP) > 1) excl_bad++;
    start = hold;
    data_in = a;
    step;
    e = 1;
    clrp1 = clrP;
    if (int'(ldA) + int'(clrP) + int'(ldP) > 1) excl_bad++;
    data_in = b;
    bound = bi + 10;
    while (done !== 1'b1 && e < bound) begin
      step;
      e++;
      start = (pulse && e == 3) ? 1'b1 : hold;
      data_in = 16'($urandom);
      if (int'(ldA) + int'(clrP) + int'(ldP) > 1) excl_bad++;
      if (ldP === 1'b1) nldp++;
      if (done !== 1'b1) begin
        exp_b = (bi > e - 2) ? bi - (e - 2) : 0;
        if (b_cnt !== 16'(exp_b)) bcnt_bad++;
      end
    end
    lat = e;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    start = 1'b1;
    data_in = 16'hFFFF;
    step;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (ldA !== 1'b0) begin errors++; $display("FAIL reset_ldA: got %b want 0", ldA); end
    checks++; if (clrP !== 1'b0) begin errors++; $display("FAIL reset_clrP: got %b want 0", clrP); end
    checks++; if (ldP !== 1'b0) begin errors++; $display("FAIL reset_ldP: got %b want 0", ldP); end
    checks++; if (b_cnt !== 16'd0) begin errors++; $display("FAIL reset_bcnt: got %0d want 0", b_cnt); end
`ifdef MUL_CYCLE_CNT_EN
    checks++; if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cyc: got %0d want 0", cyc_cnt); end
`endif
    clr = 1'b0;
    start = 1'b0;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int lat, nldp, xb, bb;
    logic l0, c1;
    run_op(16'd5, 16'd3, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
    checks++; if (l0 !== 1'b1) begin errors++; $display("FAIL basic_ldA: got %b want 1", l0); end
    checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL basic_clrP: got %b want 1", c1); end
    checks++; if (nldp != 3) begin errors++; $display("FAIL basic_nldp: got %0d want 3", nldp); end
    checks++; if (lat != 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", lat); end
    checks++; if (p_reg !== 16'd15) begin errors++; $display("FAIL basic_product: got %0d want 15", p_reg); end
    checks++; if (xb != 0) begin errors++; $display("FAIL basic_exclusive: got %0d want 0", xb); end
    checks++; if (bb != 0) begin errors++; $display("FAIL basic_bcnt: got %0d want 0", bb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy: got %b want 0", busy); end
    start = 1'b0;
    step;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_release: got %b want 0", done); end
  endtask

  task automatic test_zero_b;
    int lat, nldp, xb, bb;
    logic l0, c1;
    run_op(16'd1234, 16'd0, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
    checks++; if (nldp != 0) begin errors++; $display("FAIL zero_nldp: got %0d want 0", nldp); end
    checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", lat); end
    checks++; if (p_reg !== 16'd0) begin errors++; $display("FAIL zero_product: got %0d want 0", p_reg); end
    checks++; if (b_cnt !== 16'd0) begin errors++; $display("FAIL zero_hold: got %0d want 0", b_cnt); end
    start = 1'b0;
    step;
  endtask

  task automatic test_random;
    int lat, nldp, xb, bb;
    logic l0, c1;
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(0, 20));
      run_op(a, b, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
      checks++; if (lat != 3 + int'(b)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, 3 + int'(b)); end
      checks++; if (nldp != int'(b)) begin errors++; $display("FAIL rand_nldp[%0d]: got %0d want %0d", i, nldp, b); end
      checks++; if (p_reg !== ref_prod(a, b)) begin errors++; $display("FAIL rand_product[%0d]: got %0d want %0d", i, p_reg, ref_prod(a, b)); end
      checks++; if (xb + bb != 0) begin errors++; $display("FAIL rand_trace[%0d]: got %0d bad cycles want 0", i, xb + bb); end
      start = 1'b0;
      step;
    end
  endtask

  task automatic test_abort;
    int lat, nldp, xb, bb;
    logic l0, c1;
    start = 1'b1;
    step;
    start = 1'b0;
    data_in = 16'd9;
    step;
    data_in = 16'd5;
    step;
    step;
    step;
    step;
    checks++; if (b_cnt !== 16'd2) begin errors++; $display("FAIL abort_pre_bcnt: got %0d want 2", b_cnt); end
    checks++; if (ldP !== 1'b1) begin errors++; $display("FAIL abort_pre_ldP: got %b want 1", ldP); end
    clr = 1'b1;
    step;
    clr = 1'b0;
    checks++; if ({ldA, clrP, ldP, busy, done} !== 5'b0) begin errors++; $display("FAIL abort_outputs: got %b want 00000", {ldA, clrP, ldP, busy, done}); end
    checks++; if (b_cnt !== 16'd0) begin errors++; $display("FAIL abort_bcnt: got %0d want 0", b_cnt); end
    step;
    checks++; if ({ldA, clrP, ldP, busy} !== 4'b0) begin errors++; $display("FAIL abort_pending: got %b want 0000", {ldA, clrP, ldP, busy}); end
    run_op(16'd7, 16'd2, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
    checks++; if (p_reg !== 16'd14) begin errors++; $display("FAIL abort_next_product: got %0d want 14", p_reg); end
    checks++; if (lat != 5) begin errors++; $display("FAIL abort_next_latency: got %0d want 5", lat); end
    start = 1'b0;
    step;
  endtask

  task automatic test_hold_start;
    int lat, nldp, xb, bb;
    logic l0, c1;
    run_op(16'd3, 16'd2, 1'b1, 1'b0, lat, nldp, xb, bb, l0, c1);
    checks++; if (p_reg !== 16'd6) begin errors++; $display("FAIL hold_product: got %0d want 6", p_reg); end
    for (int i = 0; i < 4; i++) begin
      step;
      checks++; if ({done, ldA, busy} !== 3'b100) begin errors++; $display("FAIL hold_done[%0d]: got %b want 100", i, {done, ldA, busy}); end
    end
    start = 1'b0;
    step;
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL hold_release: got %b want 00", {done, busy}); end
    step;
    checks++; if (ldA !== 1'b0) begin errors++; $display("FAIL hold_no_retrigger: got %b want 0", ldA); end
  endtask

  task automatic test_pulse_in_add;
    int lat, nldp, xb, bb;
    logic l0, c1;
    logic [15:0] a;
    a = 16'($urandom);
    run_op(a, 16'd6, 1'b0, 1'b1, lat, nldp, xb, bb, l0, c1);
    checks++; if (lat != 9) begin errors++; $display("FAIL pulse_latency: got %0d want 9", lat); end
    checks++; if (nldp != 6) begin errors++; $display("FAIL pulse_nldp: got %0d want 6", nldp); end
    checks++; if (p_reg !== ref_prod(a, 16'd6)) begin errors++; $display("FAIL pulse_product: got %0d want %0d", p_reg, ref_prod(a, 16'd6)); end
    checks++; if (bb != 0) begin errors++; $display("FAIL pulse_bcnt: got %0d want 0", bb); end
    start = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    int lat, nldp, xb, bb;
    logic l0, c1;
    logic [15:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 12));
      run_op(a, b, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
      checks++; if (p_reg !== ref_prod(a, b)) begin errors++; $display("FAIL b2b_product[%0d]: got %0d want %0d", i, p_reg, ref_prod(a, b)); end
      checks++; if (lat != 3 + int'(b)) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, 3 + int'(b)); end
      start = 1'b0;
      step;
    end
  endtask

`ifdef MUL_CYCLE_CNT_EN
  task automatic test_cyc_cnt;
    int lat, nldp, xb, bb;
    logic l0, c1;
    run_op(16'd2, 16'd9, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
    checks++; if (cyc_cnt !== 16'd9) begin errors++; $display("FAIL cyc_b9: got %0d want 9", cyc_cnt); end
    start = 1'b1;
    step;
    checks++; if (cyc_cnt !== 16'd9) begin errors++; $display("FAIL cyc_hold: got %0d want 9", cyc_cnt); end
    start = 1'b0;
    step;
    run_op(16'd1, 16'hFFFF, 1'b0, 1'b0, lat, nldp, xb, bb, l0, c1);
    checks++; if (cyc_cnt !== 16'hFFFF) begin errors++; $display("FAIL cyc_sat: got %0h want ffff", cyc_cnt); end
    checks++; if (p_reg !== 16'hFFFF) begin errors++; $display("FAIL cyc_sat_product: got %0h want ffff", p_reg); end
    start = 1'b0;
    step;
  endtask
`endif

  initial begin
    clr = 1'b1;
    start = 1'b0;
    data_in = 16'd0;
    test_reset;
    test_basic;
    test_zero_b;
    test_random;
    test_abort;
    test_hold_start;
    test_pulse_in_add;
    test_back_to_back;
`ifdef MUL_CYCLE_CNT_EN
    test_cyc_cnt;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
